// File: rtl/serial_neg_pkg.sv
// Shared constants for the bit-serial negator: FSM encoding, lane slice widths
// and a counter-width helper.
package serial_neg_pkg;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam int unsigned LaneBitW = 1;
  localparam int unsigned LaneNegW = 1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_neg_lane.sv
// One bit-serial lane: two's-complement negate (or pass-through), registered
// output bit, word assembly and overflow flag.
module serial_neg_lane
  import serial_neg_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                accept_i,
  input  logic                first_i,
  input  logic                last_i,
  input  logic [LaneBitW-1:0] bit_i,
  input  logic [LaneNegW-1:0] neg_i,
  output logic [LaneBitW-1:0] out_bit_o,
  output logic [Width-1:0]    out_word_o,
  output logic                ovf_o
);

  logic             neg_q, seen_q, out_bit_q, ovf_q;
  logic [Width-2:0] asm_q;
  logic [Width-1:0] out_word_q;
  logic             neg_eff, seen_eff, res;
  logic [Width-1:0] full_word;

  // The LSB restarts the word: neg is sampled and the seen-one flag is cleared.
  assign neg_eff   = first_i ? neg_i[0] : neg_q;
  assign seen_eff  = first_i ? 1'b0 : seen_q;
  assign res       = bit_i[0] ^ (neg_eff & seen_eff);
  assign full_word = {res, asm_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_q      <= 1'b0;
      seen_q     <= 1'b0;
      out_bit_q  <= 1'b0;
      asm_q      <= '0;
      out_word_q <= '0;
      ovf_q      <= 1'b0;
    end else if (accept_i) begin
      neg_q     <= neg_eff;
      seen_q    <= seen_eff | bit_i[0];
      out_bit_q <= res;
      asm_q     <= full_word[Width-1:1];
      if (last_i) begin
        out_word_q <= full_word;
        ovf_q      <= neg_eff & bit_i[0] & res;
      end
    end
  end

  assign out_bit_o  = out_bit_q;
  assign out_word_o = out_word_q;
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/serial_negator.sv
// Multi-lane bit-serial two's-complement negator with a shared framing FSM and
// per-lane datapaths.
module serial_negator
  import serial_neg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 2
) (
  input  logic                t_clk,
  input  logic                r_n,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic [CH-1:0]       in_bit,
  input  logic [CH-1:0]       neg,
  output logic                out_valid,
  output logic [CH-1:0]       out_bit,
  output logic                word_valid,
  output logic [CH*WIDTH-1:0] out_word,
  output logic [CH-1:0]       ovf,
  output logic                frame_err
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_valid_q, word_valid_q, frame_err_q, frame_err_d;
  logic            first_acc, accept, last_acc;

  assign first_acc = in_valid & in_first;
  assign accept    = first_acc | (in_valid & (state_q == StRun));
  assign last_acc  = accept & ~in_first & (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = first_acc & (state_q == StRun) & (cnt_q != '0);
    if (first_acc) begin
      // A mid-word LSB abandons the partial word and starts a fresh one.
      state_d = StRun;
      cnt_d   = CntW'(1);
    end else if (accept) begin
      if (last_acc) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= accept;
      word_valid_q <= last_acc;
      frame_err_q  <= frame_err_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    serial_neg_lane #(
      .Width(WIDTH)
    ) u_lane (
      .clk_i     (t_clk),
      .rst_ni    (r_n),
      .accept_i  (accept),
      .first_i   (in_first),
      .last_i    (last_acc),
      .bit_i     (in_bit[k]),
      .neg_i     (neg[k]),
      .out_bit_o (out_bit[k]),
      .out_word_o(out_word[k*WIDTH +: WIDTH]),
      .ovf_o     (ovf[k])
    );
  end

  assign out_valid  = out_valid_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/serial_negator.md
SERIAL_NEGATOR -- requirements
Module: serial_negator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per serial word (legal 2..32).
REQ-002 SHALL have parameter CH, default 2, meaning independent bit-serial lanes sharing one frame (legal 1..16).
REQ-003 SHALL have port t_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port r_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning in_bit is a valid bit this cycle.
REQ-006 SHALL have port in_first, input, 1, meaning the current valid bit is the word LSB (start of frame).
REQ-007 SHALL have port in_bit, input, CH, meaning one serial data bit per lane, LSB first.
REQ-008 SHALL have port neg, input, CH, meaning per-lane mode: 1 = two's-complement negate, 0 = pass-through.
REQ-009 SHALL have port out_valid, output, 1, meaning out_bit is valid.
REQ-010 SHALL have port out_bit, output, CH, meaning the processed serial bit per lane.
REQ-011 SHALL have port word_valid, output, 1, meaning a one-cycle pulse: out_word and ovf hold a completed word.
REQ-012 SHALL have port out_word, output, CH*WIDTH, meaning the completed result words, lane k in bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port ovf, output, CH, meaning per lane: a negated word was the most negative value (-2^(WIDTH-1)).
REQ-014 SHALL have port frame_err, output, 1, meaning a one-cycle pulse: in_first arrived mid-word.

Function
REQ-015 SHALL implement FSM states IDLE and RUN with a bit counter cnt of width clog2(WIDTH).
REQ-016 SHALL, in IDLE, ignore valid bits without in_first; on in_valid&in_first it SHALL accept bit 0, set cnt=1 and enter RUN.
REQ-017 SHALL, in RUN, on in_valid, accept bit cnt and increment cnt; on accepting bit WIDTH-1 it SHALL return to IDLE (or restart at cnt=1 if that bit... not applicable; the next in_first starts a new word).
REQ-018 SHALL hold cnt and all lane state while in_valid=0 (stall, no output).
REQ-019 SHALL latch neg per lane only on the accepted LSB; neg changes mid-word SHALL have no effect until the next word.
REQ-020 SHALL, per negating lane, keep a "seen-one" flag cleared at LSB; out = in XOR seen_one_before_this_bit; seen_one sets after any accepted 1.
REQ-021 SHALL pass in_bit unchanged on non-negating lanes.
REQ-022 SHALL register out_bit and out_valid: latency exactly 1 cycle after each accepted bit; out_valid=0 otherwise.
REQ-023 SHALL shift each result bit into a per-lane assembly register; word_valid SHALL pulse in the same cycle out_valid shows bit WIDTH-1, with out_word updated that cycle and held until the next word_valid.
REQ-024 SHALL set ovf[k] = neg_latched[k] & in_msb[k] & out_msb[k], updated with word_valid and held.
REQ-025 SHALL, on in_valid&in_first while in RUN with cnt!=0, pulse frame_err one cycle later, discard the partial word (no word_valid), and treat the bit as bit 0 of a new word.
REQ-026 SHALL restrict arithmetic to modulo 2^WIDTH; negating 0 SHALL yield 0 with ovf=0.

Reset
REQ-027 SHALL, while r_n=0, force IDLE, cnt=0, seen_one=0, out_valid=0, out_bit=0, word_valid=0, out_word=0, ovf=0, frame_err=0, independent of t_clk.
REQ-028 SHALL, on reset mid-word, drop the partial word; the first word after deassertion SHALL require in_first.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE=0, RUN=1) and the lane-slice port width constants in a shared package serial_neg_pkg.
REQ-030 SHALL instantiate CH copies of sub-module serial_neg_lane (seen-one flag, output register, assembly shift register, ovf logic); the control FSM/counter SHALL be shared in the top.

Verification (WIDTH=8, CH=2)
REQ-031 SHALL verify lane0 neg=1 input 0x05 (bits 1,0,1,0,0,0,0,0) -> out bits 1,1,0,1,1,1,1,1, out_word=0xFB, ovf=0; lane1 neg=0 input 0x5A -> 0x5A.
REQ-032 SHALL verify neg=1 input 0x80 -> out_word 0x80, ovf=1; input 0x00 -> 0x00, ovf=0.
REQ-033 SHALL verify that in_valid dropped for 3 cycles after bit 3 of 0x05 still yields 0xFB with word_valid exactly once and no out_valid during the stall.
REQ-034 SHALL verify that in_first at cnt=4 pulses frame_err, suppresses word_valid, and a subsequent complete 0x01 negated yields 0xFF.
REQ-035 SHALL verify that r_n low for 1 cycle at cnt=5 clears all outputs asynchronously, with no word_valid until a full new framed word completes.
REQ-036 SHALL verify that toggling neg mid-word does not alter the current word result.
